// File: rtl/mux_8way_16.sv
// -----------------------------------------------------------------------------
// mux_8way_16
//
// Eight-input, 16-bit selector for the Hack datapath. One of eight words
// goes to `out` under the 3-bit `sel`. The selection path is combinational.
// `out_q` is a registered copy of `out` for pipelined consumers.
//
// Ports:
//   clk        in   1   rising-edge clock; it drives out_q only
//   rst        in   1   asynchronous, active-high; clears out_q
//   a..h       in  16   data words; a is selected by sel=000, h by sel=111
//   sel        in   3   unsigned select index 0..7
//   out        out 16   combinational selected word
//   out_q      out 16   selected word registered on the rising edge of clk
// -----------------------------------------------------------------------------
module mux_8way_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out,
   output logic [15:0] out_q
);

   // Leaf words, indexed by the select value that picks each one.
   logic [7:0][15:0] word;
   assign word[0] = a;
   assign word[1] = b;
   assign word[2] = c;
   assign word[3] = d;
   assign word[4] = e;
   assign word[5] = f;
   assign word[6] = g;
   assign word[7] = h;

   logic [3:0][15:0] lvl1;   // a/b, c/d, e/f, g/h under sel[0]
   logic [1:0][15:0] lvl2;   // ab/cd, ef/gh under sel[1]
   logic [15:0]      lvl3;   // abcd/efgh under sel[2]

   // Each 2:1 stage is written per bit as (x & ~s) | (y & s), so the tree
   // matches the gate-level library cells one to one.
   genvar gi, gb;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lvl1
         for (gb = 0; gb < 16; gb++) begin : g_bit
            assign lvl1[gi][gb] = (word[2*gi][gb]   & ~sel[0]) |
                                  (word[2*gi+1][gb] &  sel[0]);
         end
      end

      for (gi = 0; gi < 2; gi++) begin : g_lvl2
         for (gb = 0; gb < 16; gb++) begin : g_bit
            assign lvl2[gi][gb] = (lvl1[2*gi][gb]   & ~sel[1]) |
                                  (lvl1[2*gi+1][gb] &  sel[1]);
         end
      end

      for (gb = 0; gb < 16; gb++) begin : g_lvl3
         assign lvl3[gb] = (lvl2[0][gb] & ~sel[2]) |
                           (lvl2[1][gb] &  sel[2]);
      end
   endgenerate

   assign out = lvl3;

   // Pipeline copy with no enable. The reset clears it immediately, without
   // waiting for a clock edge. The reset has no effect on the combinational
   // path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= 16'h0000;
      end else begin
         out_q <= out;
      end
   end

endmodule

// File: tb/tb_mux_8way_16.sv
// -----------------------------------------------------------------------------
// tb_mux_8way_16
//
// Directed bench for mux_8way_16. It covers these cases:
//   - the select sweep
//   - isolation from inputs that are not selected
//   - the register path
//   - asynchronous reset
//   - reset release
// The expected values are the hand-written data words.
// -----------------------------------------------------------------------------
module tb_mux_8way_16;

   localparam logic [15:0] WA = 16'b0101010101010101;
   localparam logic [15:0] WB = 16'b1010101010101010;
   localparam logic [15:0] WC = 16'b0000000011111111;
   localparam logic [15:0] WD = 16'b1111111100000000;
   localparam logic [15:0] WE = 16'b0011001100110011;
   localparam logic [15:0] WF = 16'b1100110011001100;
   localparam logic [15:0] WG = 16'b0000111100001111;
   localparam logic [15:0] WH = 16'b1111000011110000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a, b, c, d, e, f, g, h;
   logic [2:0]  sel;
   logic [15:0] out;
   logic [15:0] out_q;

   int n_cmp = 0;
   int n_bad = 0;

   mux_8way_16 dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .e     (e),
      .f     (f),
      .g     (g),
      .h     (h),
      .sel   (sel),
      .out   (out),
      .out_q (out_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic load_data;
      a = WA; b = WB; c = WC; d = WD;
      e = WE; f = WF; g = WG; h = WH;
   endtask

   initial begin
      logic [15:0] exp_sweep [8];
      exp_sweep = '{WA, WB, WC, WD, WE, WF, WG, WH};

      // Reset state
      rst = 1'b1;
      sel = 3'd0;
      load_data();
      #1;
      check("reset_out_q", out_q, 16'h0000);
      check("reset_out", out, WA);

      // Select sweep
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         #1;
         check($sformatf("sweep_sel%0d", i), out, exp_sweep[i]);
      end

      // Isolation: d is selected; every other input is toggled
      sel = 3'd3;
      #1;
      a = ~WA; b = ~WB; c = ~WC; e = ~WE; f = ~WF; g = ~WG; h = ~WH;
      #1;
      check("iso_toggle", out, WD);
      a = 16'hFFFF; b = 16'h0000; c = 16'hDEAD; e = 16'hBEEF;
      f = 16'h0001; g = 16'h8000; h = 16'h7FFF;
      #1;
      check("iso_toggle2", out, WD);
      d = 16'h1234;
      #1;
      check("iso_d_change", out, 16'h1234);
      load_data();

      // Register path
      @(negedge clk);
      rst = 1'b0;
      sel = 3'd5;
      @(posedge clk);
      #1;
      check("reg_sel5", out_q, WF);
      sel = 3'd6;
      #1;
      check("reg_hold", out_q, WF);
      check("reg_out_sel6", out, WG);
      @(posedge clk);
      #1;
      check("reg_sel6", out_q, WG);

      // Async reset between edges
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_q", out_q, 16'h0000);
      check("async_rst_out", out, WG);
      @(posedge clk);
      #1;
      check("rst_held_q", out_q, 16'h0000);

      // Reset release
      sel = 3'd7;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release_q0", out_q, 16'h0000);
      check("release_out", out, WH);
      @(posedge clk);
      #1;
      check("release_q1", out_q, WH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
